// File: rtl/timing_mode_ctrl.sv
// Video timing mode controller: holds the active timing parameter set for a
// sync generator and sequences mode switches (wait for vsync, hold the
// generator in reset, update parameters, signal completion).
module timing_mode_ctrl #(
    parameter int unsigned DEFAULT_MODE = 2,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned VS_TIMEOUT   = 2097152
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    input  logic        I_mode_req,
    input  logic [1:0]  I_mode_sel,
    input  logic        I_vs,
    output logic [15:0] O_h_total,
    output logic [15:0] O_h_sync,
    output logic [15:0] O_h_bporch,
    output logic [15:0] O_h_res,
    output logic [15:0] O_v_total,
    output logic [15:0] O_v_sync,
    output logic [15:0] O_v_bporch,
    output logic [15:0] O_v_res,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic        O_gen_rst_n,
    output logic        O_busy,
    output logic [1:0]  O_mode_cur,
    output logic        O_mode_done
);

    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int unsigned TW        = (VS_TIMEOUT < 2) ? 1 : $clog2(VS_TIMEOUT + 1);
    localparam logic [1:0]  DEF       = 2'(DEFAULT_MODE);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(VS_TIMEOUT - 1);

    typedef struct packed {
        logic [15:0] h_total;
        logic [15:0] h_sync;
        logic [15:0] h_bporch;
        logic [15:0] h_res;
        logic [15:0] v_total;
        logic [15:0] v_sync;
        logic [15:0] v_bporch;
        logic [15:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;

    function automatic timing_t mode_table(input logic [1:0] m);
        case (m)
            2'd0:    return '{16'd1056, 16'd128, 16'd88,  16'd800,  16'd628,  16'd4, 16'd23, 16'd600,  1'b1, 1'b1};
            2'd1:    return '{16'd1344, 16'd136, 16'd160, 16'd1024, 16'd806,  16'd6, 16'd29, 16'd768,  1'b0, 1'b0};
            2'd2:    return '{16'd1650, 16'd40,  16'd220, 16'd1280, 16'd750,  16'd5, 16'd20, 16'd720,  1'b1, 1'b1};
            default: return '{16'd2200, 16'd44,  16'd148, 16'd1920, 16'd1125, 16'd5, 16'd36, 16'd1080, 1'b1, 1'b1};
        endcase
    endfunction

    logic [2:0]    state_q,    state_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    logic [1:0]    target_q,   target_d;
    logic [1:0]    mode_q,     mode_d;
    timing_t       tim_q,      tim_d;
    logic          pend_q,     pend_d;
    logic [1:0]    pend_sel_q, pend_sel_d;
    logic          ack_q,      ack_d;
    logic          vs_q, vs_d1_q;

    logic          busy;
    logic          req_any;
    logic [1:0]    sel_any;
    logic          vs_edge;

    // Next-state logic: switch sequencing, pending-request capture, counters
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;
        target_d   = target_q;
        mode_d     = mode_q;
        tim_d      = tim_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        ack_d      = 1'b0;

        busy    = (state_q != S_IDLE);
        // A live request in IDLE is newer than any stored one, so it wins
        req_any = I_mode_req | pend_q;
        sel_any = I_mode_req ? I_mode_sel : pend_sel_q;
        // Edge is judged against the polarity of the mode still applied
        vs_edge = (vs_q == tim_q.vs_pol) && (vs_d1_q != tim_q.vs_pol);

        if (busy && I_mode_req) begin
            pend_d     = 1'b1;
            pend_sel_d = I_mode_sel;
        end

        case (state_q)
            S_BOOT, S_HOLD: begin
                if (hold_cnt_q >= HOLD_LAST) begin
                    state_d    = S_DONE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_IDLE: begin
                pend_d = 1'b0;
                if (req_any) begin
                    if (sel_any != mode_q) begin
                        target_d = sel_any;
                        to_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (vs_edge || (to_cnt_q >= TO_LAST)) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                    mode_d     = target_q;
                    tim_d      = mode_table(target_q);
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_BOOT;
        endcase
    end

    // State registers with asynchronous reset into the boot sequence
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= S_BOOT;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            target_q   <= DEF;
            mode_q     <= DEF;
            tim_q      <= mode_table(DEF);
            pend_q     <= 1'b0;
            pend_sel_q <= '0;
            ack_q      <= 1'b0;
            vs_q       <= 1'b0;
            vs_d1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
            target_q   <= target_d;
            mode_q     <= mode_d;
            tim_q      <= tim_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            ack_q      <= ack_d;
            vs_q       <= I_vs;
            vs_d1_q    <= vs_q;
        end
    end

    assign O_h_total   = tim_q.h_total;
    assign O_h_sync    = tim_q.h_sync;
    assign O_h_bporch  = tim_q.h_bporch;
    assign O_h_res     = tim_q.h_res;
    assign O_v_total   = tim_q.v_total;
    assign O_v_sync    = tim_q.v_sync;
    assign O_v_bporch  = tim_q.v_bporch;
    assign O_v_res     = tim_q.v_res;
    assign O_hs_pol    = tim_q.hs_pol;
    assign O_vs_pol    = tim_q.vs_pol;
    assign O_mode_cur  = mode_q;
    assign O_gen_rst_n = !((state_q == S_BOOT) || (state_q == S_HOLD));
    assign O_busy      = (state_q != S_IDLE);
    assign O_mode_done = (state_q == S_DONE) || ack_q;

endmodule
